// File: rtl/sram_oq_write_ctrl.sv
// sram_oq_write_ctrl
// Writes the arbiter's word stream into per-queue circular regions of a shared
// SRAM. Admission is decided once per packet at start-of-packet so a queue
// never holds a truncated packet. Tracks head/tail per queue, reports
// empty/full to the read-side scheduler and accepts its pop requests.

module sram_oq_write_ctrl #(
  parameter int TDATA_WIDTH      = 24,
  parameter int DIN_WIDTH        = 8*TDATA_WIDTH+10,
  parameter int NUM_QUEUES       = 5,
  parameter int QUEUE_ID_WIDTH   = 3,
  parameter int QUEUE_ADDR_WIDTH = 12,
  parameter int MAX_PKT_WORDS    = 64
) (
  input  logic                                   memclk,
  input  logic                                   reset,
  input  logic                                   din_valid,
  input  logic [QUEUE_ID_WIDTH-1:0]              queue_id,
  input  logic [DIN_WIDTH-1:0]                   din,
  output logic                                   sram_wr_en,
  output logic [QUEUE_ID_WIDTH+QUEUE_ADDR_WIDTH-1:0] sram_addr,
  output logic [DIN_WIDTH-1:0]                   sram_wdata,
  input  logic                                   rd_en,
  input  logic [QUEUE_ID_WIDTH-1:0]              rd_queue_id,
  output logic [QUEUE_ID_WIDTH+QUEUE_ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_QUEUES-1:0]                  q_empty,
  output logic [NUM_QUEUES-1:0]                  q_full,
  output logic                                   pkt_drop,
  output logic [QUEUE_ID_WIDTH-1:0]              drop_queue
);

  localparam int PW = QUEUE_ADDR_WIDTH + 1;
  // Largest occupancy that still leaves room for a worst-case packet.
  localparam logic [PW-1:0] ADMIT_MAX = PW'((2**QUEUE_ADDR_WIDTH) - MAX_PKT_WORDS);
  localparam logic [PW-1:0] CAPACITY  = PW'(2**QUEUE_ADDR_WIDTH);
  localparam logic [QUEUE_ID_WIDTH:0] NQ = (QUEUE_ID_WIDTH+1)'(NUM_QUEUES);

  typedef enum logic [1:0] {
    ST_SOP    = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_DROP   = 2'd2
  } pkt_state_t;

  pkt_state_t      state     [NUM_QUEUES];
  pkt_state_t      state_nxt [NUM_QUEUES];
  logic [PW-1:0]   head      [NUM_QUEUES];
  logic [PW-1:0]   tail      [NUM_QUEUES];
  logic [PW-1:0]   head_nxt  [NUM_QUEUES];
  logic [PW-1:0]   tail_nxt  [NUM_QUEUES];

  logic                        wr_valid;
  logic                        wr_accept;
  logic                        wr_reject;
  logic [QUEUE_ADDR_WIDTH-1:0] wr_offset;
  logic [QUEUE_ADDR_WIDTH-1:0] rd_head;

  // Per-queue admission, packet FSM next state and pointer updates.
  // Out-of-range or unknown queue_id leaves wr_valid false, so nothing moves.
  always_comb begin
    wr_valid  = din_valid && ({1'b0, queue_id} < NQ);
    wr_accept = 1'b0;
    wr_reject = 1'b0;
    wr_offset = '0;
    for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
      head_nxt[q]  = head[q];
      tail_nxt[q]  = tail[q];
      state_nxt[q] = state[q];
      if (rd_en && (rd_queue_id == QUEUE_ID_WIDTH'(q)) && (head[q] != tail[q]))
        head_nxt[q] = head[q] + 1'b1;
      if (wr_valid && (queue_id == QUEUE_ID_WIDTH'(q))) begin
        case (state[q])
          ST_SOP: begin
            // Occupancy taken before this cycle's pop: conservative admission.
            if ((tail[q] - head[q]) <= ADMIT_MAX) begin
              wr_accept    = 1'b1;
              state_nxt[q] = din[0] ? ST_SOP : ST_ACCEPT;
            end else begin
              wr_reject    = 1'b1;
              state_nxt[q] = din[0] ? ST_SOP : ST_DROP;
            end
          end
          ST_ACCEPT: begin
            wr_accept = 1'b1;
            if (din[0]) state_nxt[q] = ST_SOP;
          end
          ST_DROP: begin
            if (din[0]) state_nxt[q] = ST_SOP;
          end
          default: state_nxt[q] = ST_SOP;
        endcase
        if (wr_accept) begin
          tail_nxt[q] = tail[q] + 1'b1;
          wr_offset   = tail[q][QUEUE_ADDR_WIDTH-1:0];
        end
      end
    end
  end

  // Read address follows the current head of the selected queue.
  always_comb begin
    rd_head = '0;
    for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
      if (rd_queue_id == QUEUE_ID_WIDTH'(q))
        rd_head = head[q][QUEUE_ADDR_WIDTH-1:0];
    end
    rd_addr = {rd_queue_id, rd_head};
  end

  // State, pointers, status flags and the registered SRAM write port.
  always_ff @(posedge memclk or posedge reset) begin
    if (reset) begin
      for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
        state[q] <= ST_SOP;
        head[q]  <= '0;
        tail[q]  <= '0;
      end
      q_empty    <= '1;
      q_full     <= '0;
      sram_wr_en <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      pkt_drop   <= 1'b0;
      drop_queue <= '0;
    end else begin
      for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
        state[q]   <= state_nxt[q];
        head[q]    <= head_nxt[q];
        tail[q]    <= tail_nxt[q];
        q_empty[q] <= (head_nxt[q] == tail_nxt[q]);
        q_full[q]  <= ((tail_nxt[q] - head_nxt[q]) == CAPACITY);
      end
      sram_wr_en <= wr_accept;
      if (wr_accept) begin
        sram_addr  <= {queue_id, wr_offset};
        sram_wdata <= din;
      end
      pkt_drop <= wr_reject;
      if (wr_reject) drop_queue <= queue_id;
    end
  end

endmodule

// File: tb/tb_sram_oq_write_ctrl.sv
// Bench for sram_oq_write_ctrl with a 16-word region per queue and 4-word
// worst-case packets. Fixed vector table, hand-written corner sequences and a
// randomized stream compared against a word-count model of each queue.

module tb_sram_oq_write_ctrl;

  localparam int QAW  = 4;
  localparam int MAXP = 4;
  localparam int NQ   = 5;
  localparam int QIW  = 3;
  localparam int DW   = 8*24+10;
  localparam int AW   = QIW + QAW;
  localparam int RGN  = 2**QAW;

  logic          memclk = 1'b0;
  logic          reset;
  logic          din_valid;
  logic [QIW-1:0] queue_id;
  logic [DW-1:0] din;
  logic          sram_wr_en;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          rd_en;
  logic [QIW-1:0] rd_queue_id;
  logic [AW-1:0] rd_addr;
  logic [NQ-1:0] q_empty;
  logic [NQ-1:0] q_full;
  logic          pkt_drop;
  logic [QIW-1:0] drop_queue;

  sram_oq_write_ctrl #(
    .QUEUE_ADDR_WIDTH(QAW),
    .MAX_PKT_WORDS(MAXP)
  ) dut (
    .memclk(memclk), .reset(reset), .din_valid(din_valid), .queue_id(queue_id),
    .din(din), .sram_wr_en(sram_wr_en), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .rd_en(rd_en), .rd_queue_id(rd_queue_id),
    .rd_addr(rd_addr), .q_empty(q_empty), .q_full(q_full),
    .pkt_drop(pkt_drop), .drop_queue(drop_queue)
  );

  always #5 memclk = ~memclk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: total words written/popped per queue, packet phase.
  int             m_wr [NQ];
  int             m_rd [NQ];
  bit             m_inpkt [NQ];
  bit             m_keep [NQ];
  logic [QIW-1:0] m_dropq;
  int             plen [8];

  typedef struct {
    bit             v;
    logic [QIW-1:0] qid;
    logic [31:0]    data;
    bit             eop;
    bit             re;
    logic [QIW-1:0] rq;
    logic [AW-1:0]  e_rdaddr;
    bit             e_wr;
    logic [AW-1:0]  e_addr;
    logic [NQ-1:0]  e_empty;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_din(input logic [31:0] data, input bit eop);
    return {{(DW-32){1'b0}}, data[31:1], eop};
  endfunction

  task automatic model_clear();
    for (int q = 0; q < NQ; q++) begin
      m_wr[q] = 0; m_rd[q] = 0; m_inpkt[q] = 0; m_keep[q] = 0;
    end
    m_dropq = '0;
  endtask

  // Leaves time at posedge+1 with reset released.
  task automatic do_reset();
    reset = 1'b1; din_valid = 1'b0; queue_id = '0; din = '0;
    rd_en = 1'b0; rd_queue_id = '0;
    repeat (2) @(posedge memclk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},   256'(sram_wr_en), 256'(0));
    check({tag, "_addr"},    256'(sram_addr),  256'(0));
    check({tag, "_wdata"},   256'(sram_wdata), 256'(0));
    check({tag, "_empty"},   256'(q_empty),    256'(5'h1f));
    check({tag, "_full"},    256'(q_full),     256'(0));
    check({tag, "_drop"},    256'(pkt_drop),   256'(0));
    check({tag, "_dropq"},   256'(drop_queue), 256'(0));
  endtask

  // One model-checked cycle; entered and left at posedge+1.
  task automatic step(input bit v, input logic [QIW-1:0] qid, input logic [31:0] data,
                      input bit eop, input bit re, input logic [QIW-1:0] rq);
    bit             e_wr, e_drop, pop, wr;
    logic [AW-1:0]  e_addr;
    logic [DW-1:0]  e_data;
    logic [NQ-1:0]  e_empty, e_full;
    din_valid = v; queue_id = qid; din = mk_din(data, eop);
    rd_en = re; rd_queue_id = rq;
    #1;
    if (rq < NQ)
      check("rd_addr", 256'(rd_addr), 256'({rq, 4'(m_rd[rq] % RGN)}));
    e_wr = 0; e_drop = 0; e_addr = '0; e_data = '0;
    pop = re && (rq < NQ) && (m_wr[rq] - m_rd[rq] > 0);
    if (v && qid < NQ) begin
      if (!m_inpkt[qid]) begin
        m_keep[qid] = (RGN - (m_wr[qid] - m_rd[qid])) >= MAXP;
        if (!m_keep[qid]) begin
          e_drop  = 1;
          m_dropq = qid;
        end
      end
      wr = m_keep[qid];
      m_inpkt[qid] = !eop;
      if (wr) begin
        e_wr   = 1;
        e_addr = {qid, 4'(m_wr[qid] % RGN)};
        e_data = mk_din(data, eop);
        m_wr[qid]++;
      end
    end
    if (pop) m_rd[rq]++;
    for (int q = 0; q < NQ; q++) begin
      e_empty[q] = (m_wr[q] == m_rd[q]);
      e_full[q]  = (m_wr[q] - m_rd[q] == RGN);
    end
    @(posedge memclk);
    #1;
    check("wr_en", 256'(sram_wr_en), 256'(e_wr));
    if (e_wr) begin
      check("wr_addr",  256'(sram_addr),  256'(e_addr));
      check("wr_data",  256'(sram_wdata), 256'(e_data));
    end
    check("pkt_drop",   256'(pkt_drop),   256'(e_drop));
    check("drop_queue", 256'(drop_queue), 256'(m_dropq));
    check("q_empty",    256'(q_empty),    256'(e_empty));
    check("q_full",     256'(q_full),     256'(e_full));
  endtask

  // Table vector: compared against constants only.
  task automatic apply_vec(input int i);
    vec_t t;
    logic [DW-1:0] d;
    t = tbl[i];
    d = mk_din(t.data, t.eop);
    din_valid = t.v; queue_id = t.qid; din = d; rd_en = t.re; rd_queue_id = t.rq;
    #1;
    check($sformatf("tbl%0d_rd_addr", i), 256'(rd_addr), 256'(t.e_rdaddr));
    @(posedge memclk);
    #1;
    check($sformatf("tbl%0d_wr_en", i), 256'(sram_wr_en), 256'(t.e_wr));
    if (t.e_wr) begin
      check($sformatf("tbl%0d_addr", i),  256'(sram_addr),  256'(t.e_addr));
      check($sformatf("tbl%0d_wdata", i), 256'(sram_wdata), 256'(d));
    end
    check($sformatf("tbl%0d_drop", i),  256'(pkt_drop), 256'(0));
    check($sformatf("tbl%0d_empty", i), 256'(q_empty),  256'(t.e_empty));
    check($sformatf("tbl%0d_full", i),  256'(q_full),   256'(0));
  endtask

  initial begin : main
    int drops, wrs;
    bit full_seen;
    int rd_pct;
    bit v, eop, re;
    logic [QIW-1:0] qid, rq;

    // 3-word packet to q2, multicast 2-word packet to q1/q3, pops, bad queue id.
    tbl[0]  = '{1, 3'd2, 32'hA1A1_0010, 0, 0, 3'd0, 7'h00, 1, 7'h20, 5'b11011};
    tbl[1]  = '{1, 3'd2, 32'hA2A2_0020, 0, 0, 3'd0, 7'h00, 1, 7'h21, 5'b11011};
    tbl[2]  = '{1, 3'd2, 32'hA3A3_0030, 1, 0, 3'd0, 7'h00, 1, 7'h22, 5'b11011};
    tbl[3]  = '{0, 3'd0, 32'h0000_0000, 0, 0, 3'd0, 7'h00, 0, 7'h00, 5'b11011};
    tbl[4]  = '{1, 3'd1, 32'hB1B1_0040, 0, 0, 3'd0, 7'h00, 1, 7'h10, 5'b11001};
    tbl[5]  = '{1, 3'd3, 32'hB1B1_0040, 0, 0, 3'd0, 7'h00, 1, 7'h30, 5'b10001};
    tbl[6]  = '{1, 3'd1, 32'hB2B2_0050, 1, 0, 3'd0, 7'h00, 1, 7'h11, 5'b10001};
    tbl[7]  = '{1, 3'd3, 32'hB2B2_0050, 1, 0, 3'd0, 7'h00, 1, 7'h31, 5'b10001};
    tbl[8]  = '{0, 3'd0, 32'h0000_0000, 0, 1, 3'd3, 7'h30, 0, 7'h00, 5'b10001};
    tbl[9]  = '{0, 3'd0, 32'h0000_0000, 0, 1, 3'd3, 7'h31, 0, 7'h00, 5'b11001};
    tbl[10] = '{0, 3'd0, 32'h0000_0000, 0, 1, 3'd3, 7'h32, 0, 7'h00, 5'b11001};
    tbl[11] = '{1, 3'd6, 32'hEEEE_00E0, 1, 0, 3'd2, 7'h20, 0, 7'h00, 5'b11001};

    reset = 1'b1; din_valid = 1'b0; queue_id = '0; din = '0;
    rd_en = 1'b0; rd_queue_id = '0;
    #2;
    check_reset_outputs("reset");
    do_reset();

    for (int i = 0; i < 12; i++) apply_vec(i);

    // Fill q0 to 13 words, then a 2-word packet must be dropped whole.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      int len;
      len = (p == 3) ? 1 : 4;
      for (int w = 0; w < len; w++) step(1, 3'd0, $urandom, (w == len-1), 0, 3'd0);
    end
    drops = 0; wrs = 0;
    step(1, 3'd0, $urandom, 0, 0, 3'd0);
    drops += int'(pkt_drop); wrs += int'(sram_wr_en);
    step(1, 3'd0, $urandom, 1, 0, 3'd0);
    drops += int'(pkt_drop); wrs += int'(sram_wr_en);
    check("drop_pulses", 256'(drops), 256'(1));
    check("drop_writes", 256'(wrs), 256'(0));
    step(0, 3'd0, 32'h0, 0, 1, 3'd0);
    step(1, 3'd0, $urandom, 1, 0, 3'd0);
    check("after_drop_sop_wr", 256'(sram_wr_en), 256'(1));
    check("after_drop_sop_addr", 256'(sram_addr), 256'(7'h0D));

    // Wrap-around on q4 with single-word packets.
    do_reset();
    full_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 3'd4, $urandom, 1, 0, 3'd0);
      check($sformatf("wrap_addr%0d", i), 256'(sram_addr), 256'({3'd4, 4'(i % RGN)}));
      full_seen |= q_full[4];
      step(0, 3'd0, 32'h0, 0, 1, 3'd4);
      full_seen |= q_full[4];
    end
    check("wrap_full_seen", 256'(full_seen), 256'(0));
    check("wrap_empty4", 256'(q_empty[4]), 256'(1));

    // Simultaneous push and pop on q1 at count 5; pop of empty q3.
    do_reset();
    for (int w = 0; w < 4; w++) step(1, 3'd1, $urandom, (w == 3), 0, 3'd0);
    step(1, 3'd1, $urandom, 1, 0, 3'd0);
    step(1, 3'd1, $urandom, 1, 1, 3'd1);
    check("samecyc_wr_addr", 256'(sram_addr), 256'(7'h15));
    rd_queue_id = 3'd1; din_valid = 1'b0; rd_en = 1'b0;
    #1 check("samecyc_head1", 256'(rd_addr), 256'(7'h11));
    step(1, 3'd1, $urandom, 1, 0, 3'd1);
    check("samecyc_next_addr", 256'(sram_addr), 256'(7'h16));
    check("samecyc_not_full", 256'(q_full[1]), 256'(0));
    step(0, 3'd0, 32'h0, 0, 1, 3'd3);
    rd_queue_id = 3'd3; rd_en = 1'b0;
    #1 check("empty_pop_head3", 256'(rd_addr), 256'(7'h30));
    @(posedge memclk); #1;

    // Asynchronous reset while q2 is mid-packet.
    do_reset();
    step(1, 3'd2, $urandom, 0, 0, 3'd0);
    check("pre_reset_wr", 256'(sram_wr_en), 256'(1));
    din_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_outputs("midpkt");
    @(negedge memclk);
    reset = 1'b0;
    model_clear();
    @(posedge memclk); #1;
    step(1, 3'd2, 32'h5151_0000, 1, 0, 3'd2);
    check("post_reset_addr", 256'(sram_addr), 256'(7'h20));

    // Randomized traffic: fill-heavy phase, then drain-heavy phase.
    do_reset();
    for (int i = 0; i < 8; i++) plen[i] = 0;
    for (int i = 0; i < 3000; i++) begin
      rd_pct = (i < 1500) ? 12 : 60;
      v   = ($urandom_range(0, 3) != 0);
      qid = 3'($urandom_range(0, 7));
      eop = (plen[qid] == MAXP-1) || ($urandom_range(0, 2) == 0);
      if (v) plen[qid] = eop ? 0 : plen[qid] + 1;
      re  = ($urandom_range(0, 99) < rd_pct);
      rq  = 3'($urandom_range(0, NQ-1));
      step(v, qid, $urandom, eop, re, rq);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_oq_write_ctrl.md
Name: sram_oq_write_ctrl

Overview:
- Sits directly downstream of the output-queue arbiter. Takes its stream of (queue_id, dout, dout_valid) words and writes each word into that queue's circular region of the shared SRAM.
- Keeps per-queue head and tail pointers, gives per-queue empty/full status to the read-side scheduler, and accepts pop requests from it.
- Admission is decided per packet at start-of-packet (SOP). A packet that might not fit is dropped whole, so a queue never holds a truncated packet.

Parameters:
- TDATA_WIDTH, 24: AXI data width in bytes.
- DIN_WIDTH, 8*TDATA_WIDTH+10: width of the word from the arbiter.
- NUM_QUEUES, 5: number of output queues.
- QUEUE_ID_WIDTH, 3: width of the queue index.
- QUEUE_ADDR_WIDTH, 12: log2 of words per queue region.
- MAX_PKT_WORDS, 64: worst-case packet length in words, used for SOP admission; must be ≤ 2^QUEUE_ADDR_WIDTH.

Ports:
- memclk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- din_valid  in  1  word valid from arbiter.
- queue_id  in  QUEUE_ID_WIDTH  target queue of the current word.
- din  in  DIN_WIDTH  word; din[0] = end-of-packet (EOP), other bits opaque.
- sram_wr_en  out  1  SRAM write strobe.
- sram_addr  out  QUEUE_ID_WIDTH+QUEUE_ADDR_WIDTH  write address {queue, tail offset}.
- sram_wdata  out  DIN_WIDTH  write data.
- rd_en  in  1  pop one word from queue rd_queue_id.
- rd_queue_id  in  QUEUE_ID_WIDTH  queue to pop.
- rd_addr  out  QUEUE_ID_WIDTH+QUEUE_ADDR_WIDTH  combinational {rd_queue_id, head offset}.
- q_empty  out  NUM_QUEUES  registered per-queue empty flags.
- q_full  out  NUM_QUEUES  registered per-queue full flags.
- pkt_drop  out  1  one-cycle pulse when a packet is rejected at SOP.
- drop_queue  out  QUEUE_ID_WIDTH  queue of the last rejected packet.

Behaviour:
- Reset (async):
  - All head/tail pointers are 0; every queue is in SOP state.
  - q_empty = all ones; q_full = 0.
  - sram_wr_en = 0, sram_addr = 0, sram_wdata = 0.
  - pkt_drop = 0, drop_queue = 0.
  - Reset mid-packet discards all queue contents and packet state.
- Pointers:
  - head and tail are QUEUE_ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - count = tail - head, modulo 2^(QUEUE_ADDR_WIDTH+1).
  - Empty when head == tail. Full when count == 2^QUEUE_ADDR_WIDTH.
  - Offsets wrap naturally from 2^QUEUE_ADDR_WIDTH-1 to 0.
- Per-queue packet FSM, one per queue, 2 bits each:
  - States: SOP, ACCEPT, DROP.
  - In SOP, when a valid word arrives for queue q:
    - If free(q) = 2^QUEUE_ADDR_WIDTH - count ≥ MAX_PKT_WORDS: write the word, go to ACCEPT; if din[0] is also set, stay in SOP.
    - Otherwise: do not write, pulse pkt_drop with drop_queue = q, go to DROP; if din[0] is also set, stay in SOP.
  - ACCEPT: write every word; return to SOP on the word with din[0] = 1.
  - DROP: discard every word; return to SOP on din[0] = 1.
  - Each queue's FSM is independent, because the arbiter replicates one multicast word to several queues on consecutive cycles.
- Write path:
  - Latency is 1 cycle: a word accepted in cycle N appears on sram_wr_en/sram_addr/sram_wdata in cycle N+1.
  - tail[q] increments in cycle N.
  - Writes are never back-pressured; the admission rule guarantees space.
- Write guard: a word with queue_id ≥ NUM_QUEUES, or queue_id containing X/Z, is ignored. No write, no state change.
- Read path:
  - rd_en on an empty queue is ignored and head does not move.
  - Otherwise head[rd_queue_id] increments at the clock edge.
  - rd_addr always reflects the current head of rd_queue_id.
- Simultaneous read and write:
  - Same queue in the same cycle: both pointers move and count is unchanged.
  - The SOP free-space check uses the count before this cycle's pop (conservative).
- Status flags:
  - q_empty and q_full are registered from the next-state pointers, so they are valid in the cycle after the update.
  - A pop in the same cycle that a queue goes full clears full one cycle later.
- Output lifetimes: pkt_drop lasts exactly one cycle per rejected packet; drop_queue holds its value until the next drop.

Test Plan:
Overrides: QUEUE_ADDR_WIDTH=4, MAX_PKT_WORDS=4.
- Single 3-word packet to q2 (EOP on word 3) → writes at sram_addr 0x20, 0x21, 0x22 on cycles N+1..N+3; q_empty[2] = 0 the cycle after the first write.
- Fill q0 to count 13, then send a 2-word packet → pkt_drop pulses once with drop_queue = 0; no sram_wr_en for either word; q0 FSM is back in SOP after the EOP word.
- Multicast: each word of a 2-word packet presented to q1 then q3 on alternate cycles → both queues receive both words, at offsets 0 and 1 in their own regions, in order.
- Wrap-around: push and pop 20 single-word packets on q4 → sram_addr offsets go 0..15 then 0..3; q_full never asserts; after the last pop q_empty[4] = 1.
- Read and write to q1 in the same cycle at count 5 → count stays 5; rd_en on empty q3 leaves head[3] = 0.
- Assert reset mid-packet while q2 is in ACCEPT → all outputs return to reset values immediately; the next word for q2 is treated as SOP.
